debounce_toggle_gen: RTL and testbench
======================================

Name: debounce_toggle_gen

Overview:
Conditions a raw, asynchronous, bouncing push-button or switch into a clean single-cycle toggle request. Its output T drives the T input of the downstream synchronous T flip-flop (syncTtrigger).
- Stages: synchronizer, then debounce state machine, then edge pulse.
- Result: one mechanical press produces exactly one toggle of the flip-flop, regardless of bounce or hold time.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the input synchronizer chain (≥2).
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required to accept a level change (≥1).
- PULSE_ON_RELEASE, 0, if 1, T also pulses when a release is accepted.
- CNT_W, localparam = $clog2(DEBOUNCE_CYCLES+1), width of the stability counter.

Ports:
- clk, input, 1, system clock, all state on rising edge.
- rst, input, 1, asynchronous active-high reset.
- btn_in, input, 1, raw asynchronous button level, active-high.
- T, output, 1, registered one-cycle toggle request to the T flip-flop.
- level, output, 1, registered debounced button level.
- busy, output, 1, high while a level change is being qualified (PRESS_WAIT or RELEASE_WAIT).

Behaviour:
- Reset (async on rst=1, held while rst=1):
  - Synchronizer chain = 0, cnt = 0, state = IDLE.
  - T = 0, level = 0, busy = 0.
- Synchronizer: btn_in is shifted through SYNC_STAGES registers. btn_sync is the last stage. The FSM never uses btn_in directly.
- FSM states: IDLE (level 0), PRESS_WAIT, PRESSED (level 1), RELEASE_WAIT.
- IDLE:
  - btn_sync=1 → PRESS_WAIT, cnt=1.
  - Otherwise stay, cnt=0.
- PRESS_WAIT:
  - btn_sync=0 → IDLE, cnt=0; this rejects the glitch.
  - btn_sync=1 and cnt==DEBOUNCE_CYCLES → PRESSED; level←1, T←1.
  - Otherwise cnt←cnt+1.
- PRESSED:
  - btn_sync=0 → RELEASE_WAIT, cnt=1.
  - Otherwise stay; T←0 after its single cycle.
- RELEASE_WAIT:
  - btn_sync=1 → PRESSED, cnt=0; level stays 1, no pulse.
  - btn_sync=0 and cnt==DEBOUNCE_CYCLES → IDLE; level←0, T←PULSE_ON_RELEASE.
  - Otherwise cnt←cnt+1.
- T is high for exactly one clock per accepted edge and is never high two consecutive cycles.
- Latency, measured from the first rising edge E0 that samples btn_in=1 with btn_in held high:
  - btn_sync=1 after edge E0+SYNC_STAGES-1.
  - T and level rise on edge E0+SYNC_STAGES+DEBOUNCE_CYCLES.
  - With defaults: T high in the cycle after edge E0+6.
  - Release latency is symmetric.
- Counter rules:
  - cnt saturates at DEBOUNCE_CYCLES; no wrap.
  - cnt is cleared on every return to IDLE or PRESSED.
- busy = (state==PRESS_WAIT) | (state==RELEASE_WAIT), decoded from registered state.
- Holding the button indefinitely: PRESSED persists, no further pulses.
- Reset mid-qualification: returns to IDLE immediately with no T pulse. After deassertion the full latency restarts even if btn_in is still high.
- DEBOUNCE_CYCLES=1: one extra stable sample beyond the synchronizer is required.
- Illegal state encoding → IDLE (default branch).

Decomposition:
- Shared include file (debounce_defs.vh): state encoding localparams ST_IDLE=2'd0, ST_PRESS_WAIT=2'd1, ST_PRESSED=2'd2, ST_RELEASE_WAIT=2'd3.
- One natural sub-module: sync_chain (parameter STAGES, ports clk, rst, d, q). It is reusable for other asynchronous inputs in the codebase.
- FSM, counter and output registers stay in debounce_toggle_gen.

Test Plan:
- Clean press, defaults: btn_in 0→1 at edge E0, held 20 cycles → T high exactly one cycle, at E0+6; level=1 from E0+6; busy high for 4 cycles before.
- Short glitch: btn_in high for 3 cycles, then 0 → T never asserts, level stays 0, busy pulses then returns to 0.
- Bounce: btn_in toggles every 1–2 cycles for 10 cycles, then stable high → exactly one T pulse, 6 cycles after the last 0→1 transition sampled.
- Long hold and release, PRESSED→RELEASE_WAIT with a 2-cycle bounce back to 1 → level stays 1, no extra T; the final clean release drops level with T=0.
- PULSE_ON_RELEASE=1: press, then release → two T pulses total, each 1 cycle; with T feeding syncTtrigger, Q returns to 0.
- Async reset asserted mid-PRESS_WAIT (cnt=2), between clock edges → T, level, busy = 0 immediately. After release of reset with btn_in still high, T asserts 6 cycles later.

Source files
------------

// File: rtl/debounce_toggle_gen_pkg.sv
// Shared types for the button debounce / toggle-request generator.
// State encoding is fixed so other blocks can decode a registered state if needed.
package debounce_toggle_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_e;

endpackage

// File: rtl/debounce_toggle_gen_sync_chain.sv
// Multi-flop synchronizer for a single asynchronous level input.
// Reusable for any async control input; q is the oldest stage.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= '0;
        else     r_sync <= {r_sync[STAGES-2:0], d};
    end

    assign q = r_sync[STAGES-1];

endmodule

// File: rtl/debounce_toggle_gen.sv
// Turns a raw bouncing button into a single-cycle toggle request (T) plus a
// clean debounced level; one accepted press gives exactly one T pulse.
module debounce_toggle_gen
    import debounce_toggle_gen_pkg::*;
#(
    parameter int SYNC_STAGES      = 2,
    parameter int DEBOUNCE_CYCLES  = 4,
    parameter bit PULSE_ON_RELEASE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic T,
    output logic level,
    output logic busy
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             w_sync;
    state_e           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_t, w_t_nxt;
    logic             r_level, w_level_nxt;

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (w_sync)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_t     <= 1'b0;
            r_level <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_t     <= w_t_nxt;
            r_level <= w_level_nxt;
        end
    end

    // cnt counts consecutive samples at the candidate level; acceptance happens
    // on the sample that finds it already at DEBOUNCE_CYCLES, so it never wraps.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_t_nxt     = 1'b0;
        w_level_nxt = r_level;
        case (r_state)
            ST_IDLE: begin
                w_level_nxt = 1'b0;
                if (w_sync) begin
                    w_state_nxt = ST_PRESS_WAIT;
                    w_cnt_nxt   = CNT_ONE;
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!w_sync) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt = ST_PRESSED;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b1;
                    w_t_nxt     = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                w_level_nxt = 1'b1;
                if (!w_sync) begin
                    w_state_nxt = ST_RELEASE_WAIT;
                    w_cnt_nxt   = CNT_ONE;
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (w_sync) begin
                    w_state_nxt = ST_PRESSED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b0;
                    w_t_nxt     = PULSE_ON_RELEASE;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_level_nxt = 1'b0;
            end
        endcase
    end

    assign T     = r_t;
    assign level = r_level;
    assign busy  = (r_state == ST_PRESS_WAIT) | (r_state == ST_RELEASE_WAIT);

endmodule

// File: tb/tb_debounce_toggle_gen.sv
// Scoreboard bench: two configurations share one button stimulus; a run-length
// debounce model predicts T/level/busy per cycle and a monitor compares them.
module tb_debounce_toggle_gen;

    localparam int S0 = 2, D0 = 4;
    localparam int S1 = 3, D1 = 1;

    logic clk, rst, btn_in;
    logic t0, l0, b0, t1, l1, b1;
    logic tff_q;

    typedef struct {
        logic t0, l0, b0, t1, l1, b1;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    logic [7:0] hist [2];
    logic       m_lvl [2];
    int         m_run [2];
    logic       m_t   [2];
    logic       m_par [2];

    debounce_toggle_gen #(.SYNC_STAGES(S0), .DEBOUNCE_CYCLES(D0), .PULSE_ON_RELEASE(1'b0)) u_def (
        .clk(clk), .rst(rst), .btn_in(btn_in), .T(t0), .level(l0), .busy(b0));

    debounce_toggle_gen #(.SYNC_STAGES(S1), .DEBOUNCE_CYCLES(D1), .PULSE_ON_RELEASE(1'b1)) u_rel (
        .clk(clk), .rst(rst), .btn_in(btn_in), .T(t1), .level(l1), .busy(b1));

    // downstream T flip-flop fed by the pulse-on-release instance
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     tff_q <= 1'b0;
        else if (t1) tff_q <= ~tff_q;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0b expected=%0b at %0t", nm, act, exp, $time);
        end
    endtask

    // Level flips once the synchronized input has differed from it for
    // D+1 consecutive samples; the sample seen at an edge is btn_in from S edges ago.
    task automatic model_step();
        exp_t e;
        int   s_n, d_n;
        logic por, smp;
        for (int i = 0; i < 2; i++) begin
            s_n = (i == 0) ? S0 : S1;
            d_n = (i == 0) ? D0 : D1;
            por = (i == 0) ? 1'b0 : 1'b1;
            m_t[i] = 1'b0;
            if (rst) begin
                hist[i]  = '0;
                m_lvl[i] = 1'b0;
                m_run[i] = 0;
                m_par[i] = 1'b0;
            end else begin
                hist[i] = {hist[i][6:0], btn_in};
                smp = hist[i][s_n];
                if (smp != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == d_n + 1) begin
                        m_lvl[i] = smp;
                        m_t[i]   = smp | por;
                        m_run[i] = 0;
                        m_par[i] = m_par[i] ^ m_t[i];
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
        e.t0 = m_t[0]; e.l0 = m_lvl[0]; e.b0 = (m_run[0] > 0);
        e.t1 = m_t[1]; e.l1 = m_lvl[1]; e.b1 = (m_run[1] > 0);
        exp_q.push_back(e);
    endtask

    task automatic cycle(input logic b, input logic r);
        @(negedge clk);
        btn_in = b;
        rst    = r;
        @(posedge clk);
        model_step();
    endtask

    task automatic hold(input logic b, input int n);
        for (int k = 0; k < n; k++) cycle(b, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("def_T", t0, e.t0);
                chk("def_level", l0, e.l0);
                chk("def_busy", b0, e.b0);
                chk("rel_T", t1, e.t1);
                chk("rel_level", l1, e.l1);
                chk("rel_busy", b1, e.b1);
            end
        end
    end

    initial begin : stim
        rst    = 1'b1;
        btn_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            hist[i] = '0; m_lvl[i] = 1'b0; m_run[i] = 0; m_t[i] = 1'b0; m_par[i] = 1'b0;
        end
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1);
        hold(1'b0, 4);

        // clean press held, then clean release
        hold(1'b1, 20);
        hold(1'b0, 12);
        chk("tff_after_press_release", tff_q, m_par[1]);

        // short glitch
        hold(1'b1, 3);
        hold(1'b0, 10);

        // bounce then stable high
        for (int k = 0; k < 10; k++) hold(k[0], $urandom_range(1, 2));
        hold(1'b1, 15);

        // release with a 2-cycle bounce back, then clean release
        hold(1'b0, 3);
        hold(1'b1, 2);
        hold(1'b0, 12);

        // async reset mid-qualification, button still high afterwards
        hold(1'b1, 4);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_def_T", t0, 1'b0);
        chk("async_rst_def_level", l0, 1'b0);
        chk("async_rst_def_busy", b0, 1'b0);
        chk("async_rst_rel_busy", b1, 1'b0);
        @(posedge clk);
        model_step();
        cycle(1'b1, 1'b1);
        hold(1'b1, 12);
        hold(1'b0, 12);

        // randomized press/bounce/release segments
        for (int seg = 0; seg < 60; seg++) begin
            hold(1'($urandom_range(0, 1)), $urandom_range(1, 12));
        end
        hold(1'b0, 15);
        chk("tff_final", tff_q, m_par[1]);

        @(negedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
